ex_mdu_ctrl: RTL and testbench

EX_MDU_CTRL -- requirements
Module: ex_mdu_ctrl

---
 rtl/ex_mdu_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_ex_mdu_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// ex_mdu_ctrl -- multiply/divide unit controller for the EX stage.
//
// Owns the architectural HI/LO registers. It runs mult/multu/div/divu as
// multi-cycle operations and stalls EX while they are in flight. mthi/mtlo
// write HI/LO directly in one cycle.
//
// Ports
//   clk       in   1   single clock, rising edge
//   resetn    in   1   asynchronous active-low reset
//   ex_valid  in   1   instruction present in EX
//   mdu_op    in   3   000 none, 001 mult, 010 multu, 011 div, 100 divu,
//                      101 mthi, 110 mtlo, 111 none
//   src1      in   32  rs operand (multiplicand / dividend / mthi-mtlo data)
//   src2      in   32  rt operand (multiplier / divisor)
//   flush     in   1   EX flush; aborts any operation in flight
//   ex_stall  out  1   hold EX while a mult/div is being started or running
//   mdu_busy  out  1   unit not idle
//   done      out  1   one-cycle pulse; HI/LO already hold the new result
//   hi, lo    out  32  architectural HI/LO
//
// Build option
//   MDU_FAST_MUL_EN  defined: single-cycle 33x33 signed multiply.
//                    undefined (default): 32-cycle shift-add multiply.
//   Division is 32-cycle radix-2 restoring in both builds.
// -----------------------------------------------------------------------------
module ex_mdu_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ex_valid,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        flush,
  output logic        ex_stall,
  output logic        mdu_busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  // a_q: dividend/quotient or multiplier/product-low shift register.
  // b_q: divisor or multiplicand. rem_q: partial remainder or product-high.
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] rem_q;
  logic        neg_q;   // negate quotient / product at the end
  logic        rneg_q;  // negate remainder at the end
  logic [31:0] hi_q;
  logic [31:0] lo_q;
`ifdef MDU_FAST_MUL_EN
  logic        sgn_q;   // signed multiply: sign-extend raw operands
`endif

  // ---------------------------------------------------------------------------
  // Start decode and operand magnitudes
  // ---------------------------------------------------------------------------
  logic        start;
  logic        op_signed;
  logic        op_is_mul;
  logic        s1_neg;
  logic        s2_neg;
  logic [31:0] mag1;
  logic [31:0] mag2;

  always_comb begin
    start     = (state_q == S_IDLE) && ex_valid && !flush &&
                (mdu_op >= 3'd1) && (mdu_op <= 3'd4);
    op_signed = (mdu_op == 3'd1) || (mdu_op == 3'd3);
    op_is_mul = (mdu_op == 3'd1) || (mdu_op == 3'd2);
    s1_neg    = op_signed && src1[31];
    s2_neg    = op_signed && src2[31];
    mag1      = s1_neg ? (32'd0 - src1) : src1;
    mag2      = s2_neg ? (32'd0 - src2) : src2;
  end

  // ---------------------------------------------------------------------------
  // One restoring-division step and the sign-corrected final result
  // ---------------------------------------------------------------------------
  logic [32:0] div_sh;
  logic [32:0] div_diff;
  logic [31:0] div_rem_d;
  logic [31:0] div_quo_d;
  logic [31:0] div_hi_d;
  logic [31:0] div_lo_d;

  always_comb begin
    div_sh   = {rem_q, a_q[31]};
    div_diff = div_sh - {1'b0, b_q};
    if (!div_diff[32]) begin
      div_rem_d = div_diff[31:0];
      div_quo_d = {a_q[30:0], 1'b1};
    end else begin
      div_rem_d = div_sh[31:0];
      div_quo_d = {a_q[30:0], 1'b0};
    end
    div_lo_d = neg_q  ? (32'd0 - div_quo_d) : div_quo_d;
    div_hi_d = rneg_q ? (32'd0 - div_rem_d) : div_rem_d;
  end

  // ---------------------------------------------------------------------------
  // Multiply datapath
  // ---------------------------------------------------------------------------
`ifdef MDU_FAST_MUL_EN
  logic signed [32:0] fa;
  logic signed [32:0] fb;
  logic signed [63:0] fast_prod;

  always_comb begin
    fa        = {sgn_q && a_q[31], a_q};
    fb        = {sgn_q && b_q[31], b_q};
    fast_prod = fa * fb;
  end
`else
  // Shift-add: add multiplicand into the high half when the multiplier LSB
  // is set, then shift the 65-bit {carry, high, low} right by one.
  logic [32:0] mul_sum;
  logic [31:0] mul_hi_d;
  logic [31:0] mul_lo_d;
  logic [63:0] mul_res;

  always_comb begin
    mul_sum  = {1'b0, rem_q} + (a_q[0] ? {1'b0, b_q} : 33'd0);
    mul_hi_d = mul_sum[32:1];
    mul_lo_d = {mul_sum[0], a_q[31:1]};
    mul_res  = neg_q ? (64'd0 - {mul_hi_d, mul_lo_d}) : {mul_hi_d, mul_lo_d};
  end
`endif

  logic last_iter;
  assign last_iter = (cnt_q == 6'd31);

  // ---------------------------------------------------------------------------
  // Control FSM, iteration registers and HI/LO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rem_q   <= 32'd0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
`ifdef MDU_FAST_MUL_EN
      sgn_q   <= 1'b0;
`endif
    end else if (flush) begin
      // Abort without touching HI/LO; also blocks a same-cycle start.
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q   <= 6'd0;
            rem_q   <= 32'd0;
            neg_q   <= s1_neg ^ s2_neg;
            rneg_q  <= s1_neg;
            state_q <= op_is_mul ? S_MUL : S_DIV;
`ifdef MDU_FAST_MUL_EN
            sgn_q   <= op_signed;
            // The fast multiplier takes raw operands and handles sign itself.
            a_q     <= op_is_mul ? src1 : mag1;
            b_q     <= op_is_mul ? src2 : mag2;
`else
            a_q     <= mag1;
            b_q     <= mag2;
`endif
          end else if (ex_valid && (mdu_op == 3'd5)) begin
            hi_q <= src1;
          end else if (ex_valid && (mdu_op == 3'd6)) begin
            lo_q <= src1;
          end
        end

        S_MUL: begin
`ifdef MDU_FAST_MUL_EN
          hi_q    <= fast_prod[63:32];
          lo_q    <= fast_prod[31:0];
          state_q <= S_DONE;
`else
          rem_q <= mul_hi_d;
          a_q   <= mul_lo_d;
          cnt_q <= cnt_q + 6'd1;
          if (last_iter) begin
            hi_q    <= mul_res[63:32];
            lo_q    <= mul_res[31:0];
            state_q <= S_DONE;
          end
`endif
        end

        S_DIV: begin
          rem_q <= div_rem_d;
          a_q   <= div_quo_d;
          cnt_q <= cnt_q + 6'd1;
          if (last_iter) begin
            hi_q    <= div_hi_d;
            lo_q    <= div_lo_d;
            state_q <= S_DONE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ex_stall = start || (state_q == S_MUL) || (state_q == S_DIV);
  assign mdu_busy = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_ex_mdu_ctrl.sv
module tb_ex_mdu_ctrl;

  logic        clk;
  logic        resetn;
  logic        ex_valid;
  logic [2:0]  mdu_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        ex_stall;
  logic        mdu_busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int failures;

  // Reference copy of HI/LO.
  logic [31:0] hi_m;
  logic [31:0] lo_m;

`ifdef MDU_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  ex_mdu_ctrl dut (
    .clk      (clk),
    .resetn   (resetn),
    .ex_valid (ex_valid),
    .mdu_op   (mdu_op),
    .src1     (src1),
    .src2     (src2),
    .flush    (flush),
    .ex_stall (ex_stall),
    .mdu_busy (mdu_busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural result {HI, LO} computed from the instruction definition.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = 64'd0;
    case (op)
      3'd1: r = 64'(sa * sb);
      3'd2: r = {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (b == 32'd0) r = {a, (a[31] ? 32'd1 : 32'hFFFFFFFF)};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      3'd4: begin
        if (b == 32'd0) r = {a, 32'hFFFFFFFF};
        else r = {a % b, a / b};
      end
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one mult/div at the current cycle (T) and follow it to completion.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int cycles;
    int stall_bad;
    int lat;
    logic [63:0] exp;
    exp = model(op, a, b);
    lat = (op <= 3'd2) ? MUL_LAT : DIV_LAT;
    ex_valid = 1'b1; mdu_op = op; src1 = a; src2 = b;
    #1;
    chk("stall_at_accept", {63'd0, ex_stall}, 64'd1);
    tick();
    ex_valid = 1'b0; mdu_op = 3'd0;
    cycles = 1;
    stall_bad = 0;
    while (!done && cycles < 60) begin
      if (ex_stall !== 1'b1) stall_bad++;
      tick();
      cycles++;
    end
    chk("latency", 64'(cycles), 64'(lat));
    chk("stall_while_busy", 64'(stall_bad), 64'd0);
    chk("stall_in_done", {63'd0, ex_stall}, 64'd0);
    chk("result_hi_lo", {hi, lo}, exp);
    hi_m = exp[63:32];
    lo_m = exp[31:0];
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h cycles=%0d", op, a, b, hi, lo, cycles);
    tick();
    chk("idle_after_done", {62'd0, done, mdu_busy}, 64'd0);
  endtask

  task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
    ex_valid = 1'b1; mdu_op = op; src1 = a; src2 = 32'd0;
    #1;
    chk("mt_no_stall", {63'd0, ex_stall}, 64'd0);
    tick();
    ex_valid = 1'b0; mdu_op = 3'd0;
    if (op == 3'd5) hi_m = a; else lo_m = a;
    chk("mt_hi_lo", {hi, lo}, {hi_m, lo_m});
    chk("mt_no_done_busy", {62'd0, done, mdu_busy}, 64'd0);
    $display("mt op=%0d data=%h -> hi=%h lo=%h", op, a, hi, lo);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          done_seen;

    checks = 0; failures = 0;
    hi_m = 32'd0; lo_m = 32'd0;
    resetn = 1'b0; ex_valid = 1'b0; mdu_op = 3'd0;
    src1 = 32'd0; src2 = 32'd0; flush = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi_lo", {hi, lo}, 64'd0);
    chk("reset_ctrl", {61'd0, ex_stall, mdu_busy, done}, 64'd0);
    resetn = 1'b1;
    tick();

    // Directed vectors
    run_op(3'd4, 32'd100, 32'd7);
    run_op(3'd3, 32'hFFFFFFF9, 32'd2);
    run_op(3'd4, 32'd5, 32'd0);
    run_op(3'd3, 32'hFFFFFFF9, 32'd0);
    run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
    run_op(3'd1, 32'hFFFFFFFF, 32'd2);
    run_op(3'd2, 32'hFFFFFFFF, 32'd2);
    run_op(3'd1, 32'h80000000, 32'h80000000);

    // mthi then a normal mult
    run_mt(3'd5, 32'h12345678);
    run_op(3'd1, 32'h00001234, 32'hFFFF0000);
    run_mt(3'd6, 32'hCAFEF00D);

    // Flush in the start cycle suppresses acceptance
    ex_valid = 1'b1; mdu_op = 3'd3; src1 = 32'd77; src2 = 32'd3; flush = 1'b1;
    #1;
    chk("flush_start_stall", {63'd0, ex_stall}, 64'd0);
    tick();
    ex_valid = 1'b0; mdu_op = 3'd0; flush = 1'b0;
    chk("flush_start_busy", {63'd0, mdu_busy}, 64'd0);
    $display("flush in start cycle -> busy=%b", mdu_busy);

    // Flush at T+10 of a div
    ex_valid = 1'b1; mdu_op = 3'd3; src1 = 32'd1000; src2 = 32'd9;
    tick();
    ex_valid = 1'b0; mdu_op = 3'd0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_mid_ctrl", {61'd0, ex_stall, mdu_busy, done}, 64'd0);
    done_seen = 0;
    repeat (30) begin
      if (done) done_seen++;
      tick();
    end
    chk("flush_no_done", 64'(done_seen), 64'd0);
    chk("flush_hi_lo_kept", {hi, lo}, {hi_m, lo_m});
    $display("flush at T+10 -> hi=%h lo=%h done_seen=%0d", hi, lo, done_seen);

    // Reset during DIV cycle 20
    ex_valid = 1'b1; mdu_op = 3'd4; src1 = 32'hDEADBEEF; src2 = 32'd13;
    tick();
    ex_valid = 1'b0; mdu_op = 3'd0;
    repeat (19) tick();
    resetn = 1'b0;
    #1;
    chk("midreset_hi_lo", {hi, lo}, 64'd0);
    chk("midreset_ctrl", {61'd0, ex_stall, mdu_busy, done}, 64'd0);
    hi_m = 32'd0; lo_m = 32'd0;
    tick();
    tick();
    resetn = 1'b1;
    tick();
    chk("post_reset_idle", {63'd0, mdu_busy}, 64'd0);
    $display("reset mid-div -> hi=%h lo=%h busy=%b", hi, lo, mdu_busy);
    run_op(3'd4, 32'hDEADBEEF, 32'd13);

    // Randomized operations
    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(1, 6));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      if (rop >= 3'd5) run_mt(rop, ra);
      else run_op(rop, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
